// File: rtl/add_seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle slice-serial adder sequencer.
// Holds the FSM state encoding, ALU op codes and a width helper.
package add_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic OpAdd = 1'b0;
    localparam logic OpSub = 1'b1;

    // Counter width that stays legal when only one slice exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_ripple.sv
// Narrow ripple-carry adder slice; the sequencer reuses one instance for
// every slice of a wide operation.
module add_ripple #(
    parameter int unsigned W = 3
) (
    output logic [W-1:0] sum,
    output logic         c_out,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = c_in;
        for (int unsigned i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide add/subtract built from one add_ripple slice, processed LSB slice first
// over NUM_SLICES cycles with the carry held in a register between slices.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int unsigned SLICE_W    = 3,
    parameter int unsigned NUM_SLICES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            op_sub,
    input  logic [SLICE_W*NUM_SLICES-1:0]   a,
    input  logic [SLICE_W*NUM_SLICES-1:0]   b,
    output logic                            ready,
    output logic                            done,
    output logic [SLICE_W*NUM_SLICES-1:0]   result,
    output logic                            c_out,
    output logic                            ovf
);

    localparam int unsigned OP_W  = SLICE_W * NUM_SLICES;
    localparam int unsigned IDX_W = idx_width(NUM_SLICES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [OP_W-1:0]    a_q, b_q, result_q;
    logic               c_out_q, ovf_q;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_c;
    logic               last_slice;
    logic               accept;

    assign last_slice = (idx_q == IDX_W'(NUM_SLICES - 1));
    assign accept     = start && ready;

    // Operand slice mux; b_q already holds ~b for subtraction.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NUM_SLICES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    add_ripple #(
        .W (SLICE_W)
    ) u_add_ripple (
        .sum   (slice_sum),
        .c_out (slice_c),
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_slice) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready = (state_q == StIdle) || (state_q == StDone);
        done  = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            idx_q    <= '0;
            carry_q  <= (op_sub == OpSub);
            a_q      <= a;
            b_q      <= (op_sub == OpSub) ? ~b : b;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (state_q == StRun) begin
            for (int unsigned i = 0; i < NUM_SLICES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    result_q[i*SLICE_W +: SLICE_W] <= slice_sum;
                end
            end
            carry_q <= slice_c;
            idx_q   <= last_slice ? '0 : idx_q + 1'b1;
            if (last_slice) begin
                c_out_q <= slice_c;
                ovf_q   <= (a_q[OP_W-1] == b_q[OP_W-1]) &&
                           (slice_sum[SLICE_W-1] != a_q[OP_W-1]);
            end
        end
    end

    assign result = result_q;
    assign c_out  = c_out_q;
    assign ovf    = ovf_q;

endmodule
